// File: rtl/barret_pkg.sv
// Shared constants and types for the q = 499 modular datapath blocks.
package barret_pkg;

  localparam int Q_499 = 499;
  localparam int RES_W = 9;

  // Accumulator control states: collecting residues, or holding a block sum.
  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_e;

endpackage : barret_pkg

// File: rtl/mod_add_499.sv
// Combinational modular adder: y = (a + b) mod Q for a, b < Q.
// One extra bit holds the raw sum. Because both operands are below Q,
// one conditional subtract always brings the result back into range.
module mod_add_499
  import barret_pkg::*;
#(
  parameter int Q = Q_499,
  parameter int W = RES_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  localparam logic [W:0] Q_EXT = (W+1)'(Q);

  logic [W:0] sum_s;

  // Wide add followed by a single conditional subtract of Q.
  always_comb begin
    sum_s = {1'b0, a} + {1'b0, b};
    if (sum_s >= Q_EXT) begin
      y = W'(sum_s - Q_EXT);
    end else begin
      y = sum_s[W-1:0];
    end
  end

endmodule : mod_add_499

// File: rtl/mod_accum_499.sv
// Block accumulator modulo Q (499). Collects BLOCK_LEN residues over a
// valid/ready input, then presents their sum mod Q on a valid/ready output.
// All outputs are registered; din_ready is held low while a sum is pending.
// Optional build macro MOD_ACCUM_RANGE_CHECK_EN: out-of-range inputs are
// pre-reduced by one subtract of Q and the sticky err flag is raised.
// Without the macro, err stays 0 and inputs >= Q are not handled.
module mod_accum_499
  import barret_pkg::*;
#(
  parameter int Q         = Q_499,
  parameter int W         = RES_W,
  parameter int BLOCK_LEN = 8,
  parameter int CNT_W     = $clog2(BLOCK_LEN + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic [W-1:0] din_a,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic [W-1:0] dout_r,
  output logic         err
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

  acc_state_e       state_r;
  logic [W-1:0]     acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic [W-1:0]     din_red_s;
  logic [W-1:0]     sum_s;
  logic             accept_s;

`ifdef MOD_ACCUM_RANGE_CHECK_EN
  localparam logic [W:0] Q_EXT = (W+1)'(Q);
  logic oor_s;

  // Fold an out-of-range input back below Q with one compare/subtract.
  always_comb begin
    oor_s     = 1'b0;
    din_red_s = din_a;
    if ({1'b0, din_a} >= Q_EXT) begin
      oor_s     = 1'b1;
      din_red_s = W'({1'b0, din_a} - Q_EXT);
    end else begin
      oor_s     = 1'b0;
      din_red_s = din_a;
    end
  end
`else
  // Inputs are trusted to be below Q; pass them straight to the adder.
  always_comb begin
    din_red_s = din_a;
  end
`endif

  // An input is consumed only when offered while the block is collecting.
  always_comb begin
    accept_s = din_valid & din_ready;
  end

  mod_add_499 #(
    .Q (Q),
    .W (W)
  ) u_add (
    .a (acc_r),
    .b (din_red_s),
    .y (sum_s)
  );

  // Control FSM with registered handshake outputs, running sum and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ACC;
      acc_r      <= {W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      din_ready  <= 1'b1;
      dout_valid <= 1'b0;
      dout_r     <= {W{1'b0}};
      err        <= 1'b0;
    end else begin
      case (state_r)
        ACC: begin
          if (accept_s) begin
`ifdef MOD_ACCUM_RANGE_CHECK_EN
            if (oor_s) begin
              err <= 1'b1;
            end else begin
              err <= err;
            end
`endif
            if (cnt_r == LAST_CNT) begin
              dout_r     <= sum_s;
              dout_valid <= 1'b1;
              acc_r      <= {W{1'b0}};
              cnt_r      <= {CNT_W{1'b0}};
              din_ready  <= 1'b0;
              state_r    <= HOLD;
            end else begin
              acc_r <= sum_s;
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
          end
        end
        HOLD: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            din_ready  <= 1'b1;
            state_r    <= ACC;
          end else begin
            dout_valid <= 1'b1;
            din_ready  <= 1'b0;
          end
        end
        default: begin
          state_r    <= ACC;
          acc_r      <= {W{1'b0}};
          cnt_r      <= {CNT_W{1'b0}};
          din_ready  <= 1'b1;
          dout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : mod_accum_499

// File: tb/tb_mod_accum_499.sv
// Self-checking bench for mod_accum_499 (default parameters Q=499, BLOCK_LEN=8).
// A queue-based model collects accepted residues and predicts each block sum
// as (sum of the block) % Q; outputs are compared one time unit after every edge.
module tb_mod_accum_499;

  localparam int Q  = 499;
  localparam int W  = 9;
  localparam int BL = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic [W-1:0] din_a = '0;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic [W-1:0] dout_r;
  logic         err;

  always #5 clk = ~clk;

  mod_accum_499 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_a      (din_a),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_r     (dout_r),
    .err        (err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state.
  int blk[$];
  bit m_valid;
  int m_dout;
  bit m_err;
  int blocks_out;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    blk.delete();
    m_valid = 1'b0;
    m_dout  = 0;
    m_err   = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT sees.
  task automatic model_edge();
    int v;
    int s;
    if (!rst_n) begin
      model_reset();
    end else if (!m_valid) begin
      if (din_valid) begin
        v = int'(din_a);
        if (v >= Q) begin
          m_err = 1'b1;
          v = v % Q;
        end
        blk.push_back(v);
        if (blk.size() == BL) begin
          s = 0;
          foreach (blk[i]) s += blk[i];
          m_dout  = s % Q;
          m_valid = 1'b1;
          blk.delete();
        end
      end
    end else if (dout_ready) begin
      m_valid = 1'b0;
      blocks_out++;
    end
  endtask

  task automatic compare_outputs();
    chk("din_ready", int'(din_ready), int'(!m_valid));
    chk("dout_valid", int'(dout_valid), int'(m_valid));
    chk("dout_r", int'(dout_r), m_dout);
`ifdef MOD_ACCUM_RANGE_CHECK_EN
    chk("err", int'(err), int'(m_err));
`else
    chk("err", int'(err), 0);
`endif
  endtask

  task automatic cycle(input bit v, input int a, input bit r);
    din_valid  = v;
    din_a      = W'(a);
    dout_ready = r;
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  initial begin
    int budget;
    model_reset();
    blocks_out = 0;

    // Reset state.
    #12;
    compare_outputs();
    chk("reset_din_ready", int'(din_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: 1..8 back-to-back, sink always ready.
    for (int i = 1; i <= 8; i++) cycle(1'b1, i, 1'b1);
    chk("t1_sum", int'(dout_r), 36);
    chk("t1_valid", int'(dout_valid), 1);
    chk("t1_ready_low", int'(din_ready), 0);
    cycle(1'b1, 9, 1'b1);
    chk("t1_ready_back", int'(din_ready), 1);
    chk("t1_valid_drop", int'(dout_valid), 0);

    // Test 2: eight 498s.
    for (int i = 0; i < 8; i++) cycle(1'b1, 498, 1'b1);
    chk("t2_sum", int'(dout_r), 491);
    cycle(1'b0, 0, 1'b1);

    // Test 3: hold the sum with dout_ready low while inputs keep coming.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 50 * i, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 7, 1'b0);
      chk("t3_hold_sum", int'(dout_r), 303);
      chk("t3_hold_ready", int'(din_ready), 0);
    end
    cycle(1'b0, 0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1, 1'b0);
    chk("t3_next_sum", int'(dout_r), 8);
    cycle(1'b0, 0, 1'b1);

    // Test 4: reset in the middle of a block.
    for (int i = 0; i < 3; i++) cycle(1'b1, 10, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1'b1, 100, 1'b1);
    chk("t4_sum", int'(dout_r), 301);
    cycle(1'b0, 0, 1'b1);

    // Test 5: random gaps and backpressure over 200 blocks.
    blocks_out = 0;
    budget = 0;
    while (blocks_out < 200 && budget < 20000) begin
      bit v;
      bit r;
      int a;
      v = ($urandom_range(0, 3) != 0);
      a = v ? int'($urandom_range(0, Q - 1)) : int'($urandom_range(0, 511));
      r = ($urandom_range(0, 1) != 0);
      cycle(v, a, r);
      budget++;
    end
    chk("t5_blocks", blocks_out, 200);
    cycle(1'b0, 0, 1'b1);
    cycle(1'b0, 0, 1'b1);

`ifdef MOD_ACCUM_RANGE_CHECK_EN
    // Test 6: out-of-range input is folded and flagged.
    cycle(1'b1, 505, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b1, 0, 1'b1);
    chk("t6_sum", int'(dout_r), 6);
    chk("t6_err", int'(err), 1);
    cycle(1'b0, 0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 2, 1'b1);
    chk("t6_sum2", int'(dout_r), 16);
    chk("t6_err_sticky", int'(err), 1);
`else
    chk("t6_err_off", int'(err), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mod_accum_499
